// File: rtl/tower_pkg.sv
// Shared constants and helpers for the tower playfield drawer.
// Holds FSM state codes, default geometry, palette and map addressing.
package tower_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FULL  = 3'd1;
  localparam state_t ST_ERASE = 3'd2;
  localparam state_t ST_DRAW  = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam int unsigned DEF_H_RES = 160;
  localparam int unsigned DEF_V_RES = 120;
  localparam int unsigned DEF_SPR_W = 4;
  localparam int unsigned DEF_SPR_H = 4;

  localparam logic [2:0] C_BG   = 3'b000;
  localparam logic [2:0] C_WALL = 3'b111;
  localparam logic [2:0] C_DUDE = 3'b100;

  // Linear wall-map address of a playfield point.
  function automatic int unsigned map_addr(input int unsigned px,
                                           input int unsigned py,
                                           input int unsigned h_res);
    return py * h_res + px;
  endfunction

endpackage

// File: rtl/tower_box_scanner.sv
// Row-major rectangle walker: one point per step, reports clipping and the last point.
// Coordinates carry one extra bit so boxes hanging off the edge never wrap on-screen.
module tower_box_scanner #(
  parameter int          X_W   = 8,
  parameter int          Y_W   = 7,
  parameter int unsigned H_RES = 160,
  parameter int unsigned V_RES = 120
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [X_W:0] org_x,
  input  logic [Y_W:0] org_y,
  input  logic [X_W:0] ext_w,
  input  logic [Y_W:0] ext_h,
  output logic [X_W:0] sx,
  output logic [Y_W:0] sy,
  output logic         in_range,
  output logic         last
);

  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

  logic [X_W:0] ox, ew, cx;
  logic [Y_W:0] oy, eh, cy;
  logic         row_end;

  assign row_end = (cx == ew - 1'b1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox <= '0;
      oy <= '0;
      ew <= '0;
      eh <= '0;
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      ox <= org_x;
      oy <= org_y;
      ew <= ext_w;
      eh <= ext_h;
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (row_end) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign sx       = ox + cx;
  assign sy       = oy + cy;
  assign in_range = (sx < H_LIM) && (sy < V_LIM);
  assign last     = row_end && (cy == eh - 1'b1);

endmodule

// File: rtl/tower_frame_drawer.sv
// Pixel-plot sequencer: full-frame or incremental sprite redraw into the VGA frame buffer.
// Stage 1 presents the wall-map address, stage 2 registers the plot one cycle later.
module tower_frame_drawer
  import tower_pkg::*;
#(
  parameter int unsigned          H_RES       = DEF_H_RES,
  parameter int unsigned          V_RES       = DEF_V_RES,
  parameter int                   X_W         = 8,
  parameter int                   Y_W         = 7,
  parameter int                   ADDR_W      = 15,
  parameter int                   COLOUR_W    = 3,
  parameter int unsigned          SPR_W       = DEF_SPR_W,
  parameter int unsigned          SPR_H       = DEF_SPR_H,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR   = C_BG,
  parameter logic [COLOUR_W-1:0]  WALL_COLOUR = C_WALL,
  parameter logic [COLOUR_W-1:0]  DUDE_COLOUR = C_DUDE
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                mode_inc,
  input  logic [X_W-1:0]      dude_x,
  input  logic [Y_W-1:0]      dude_y,
  output logic [ADDR_W-1:0]   wall_addr,
  input  logic                wall_rd_data,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W:0] H_EXT = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_EXT = (Y_W+1)'(V_RES);
  localparam logic [X_W:0] SW_E  = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0] SH_E  = (Y_W+1)'(SPR_H);

  state_t       state, next_state;
  logic [X_W:0] lat_x, old_x, ld_x, ld_w, sx;
  logic [Y_W:0] lat_y, old_y, ld_y, ld_h, sy;
  logic         prev_valid, sc_load, sc_step, in_range, last, scanning, in_dude;

  logic [X_W-1:0]      s1_x;
  logic [Y_W-1:0]      s1_y;
  logic                s1_in, s1_dude;
  state_t              s1_state;
  logic [COLOUR_W-1:0] s2_colour;

  tower_box_scanner #(
    .X_W(X_W), .Y_W(Y_W), .H_RES(H_RES), .V_RES(V_RES)
  ) u_scan (
    .clk(CLOCK_50), .rst_n(resetn), .load(sc_load), .step(sc_step),
    .org_x(ld_x), .org_y(ld_y), .ext_w(ld_w), .ext_h(ld_h),
    .sx(sx), .sy(sy), .in_range(in_range), .last(last)
  );

  assign scanning = (state == ST_FULL) || (state == ST_ERASE) || (state == ST_DRAW);
  assign in_dude  = (sx >= lat_x) && (sx < lat_x + SW_E) && (sy >= lat_y) && (sy < lat_y + SH_E);

  // Clipped points still take a cycle but address row 0 harmlessly.
  assign wall_addr = (scanning && in_range)
                   ? ADDR_W'(map_addr(32'(sx), 32'(sy), H_RES)) : '0;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    sc_load    = 1'b0;
    sc_step    = 1'b0;
    ld_x       = '0;
    ld_y       = '0;
    ld_w       = H_EXT;
    ld_h       = V_EXT;
    case (state)
      ST_IDLE: if (start) begin
        sc_load = 1'b1;
        if (mode_inc && prev_valid) begin
          ld_x       = old_x;
          ld_y       = old_y;
          ld_w       = SW_E;
          ld_h       = SH_E;
          next_state = ST_ERASE;
        end else begin
          next_state = ST_FULL;
        end
      end
      ST_FULL, ST_DRAW: begin
        sc_step = 1'b1;
        if (last) next_state = ST_FLUSH;
      end
      ST_ERASE: begin
        sc_step = 1'b1;
        if (last) begin
          // Reload straight onto the new box so DRAW follows with no gap.
          sc_load    = 1'b1;
          ld_x       = lat_x;
          ld_y       = lat_y;
          ld_w       = SW_E;
          ld_h       = SH_E;
          next_state = ST_DRAW;
        end
      end
      ST_FLUSH: next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    s2_colour = wall_rd_data ? WALL_COLOUR : BG_COLOUR;
    if (s1_state == ST_DRAW || (s1_state == ST_FULL && s1_dude))
      s2_colour = DUDE_COLOUR;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      lat_x      <= '0;
      lat_y      <= '0;
      old_x      <= '0;
      old_y      <= '0;
      prev_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (state != ST_IDLE);
      done  <= (state == ST_DONE);
      if (state == ST_IDLE && start) begin
        lat_x <= {1'b0, dude_x};
        lat_y <= {1'b0, dude_y};
      end
      if (state == ST_DONE) begin
        old_x      <= lat_x;
        old_y      <= lat_y;
        prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_in    <= 1'b0;
      s1_dude  <= 1'b0;
      s1_state <= ST_IDLE;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
    end else begin
      s1_x     <= sx[X_W-1:0];
      s1_y     <= sy[Y_W-1:0];
      s1_in    <= scanning && in_range;
      s1_dude  <= in_dude;
      s1_state <= state;
      plot     <= s1_in;
      if (s1_in) begin
        x      <= s1_x;
        y      <= s1_y;
        colour <= s2_colour;
      end
    end
  end

endmodule

// File: tb/tb_tower_frame_drawer.sv
// Directed bench for tower_frame_drawer on an 8x4 playfield, 2x2 sprite, wall on row 3.
// Cycle 0 is the cycle right after the clock edge that samples start.
module tb_tower_frame_drawer;

  localparam int H = 8, V = 4, XW = 3, YW = 2, AW = 5, CW = 3, SW = 2, SH = 2;
  localparam logic [2:0] BG = 3'b000, WALL = 3'b111, DUDE = 3'b100;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, mode_inc = 1'b0;
  logic [XW-1:0] dude_x = '0;
  logic [YW-1:0] dude_y = '0;
  logic [AW-1:0] wall_addr;
  logic          wall_rd_data = 1'b0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot, busy, done;

  int errors = 0, checks = 0;
  int exp_q[$], got_q[$];
  logic [2:0] fb [0:H-1][0:V-1];

  tower_frame_drawer #(
    .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .COLOUR_W(CW),
    .SPR_W(SW), .SPR_H(SH), .BG_COLOUR(BG), .WALL_COLOUR(WALL), .DUDE_COLOUR(DUDE)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .mode_inc(mode_inc),
    .dude_x(dude_x), .dude_y(dude_y), .wall_addr(wall_addr), .wall_rd_data(wall_rd_data),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Wall map: bit set iff y == 3, i.e. addresses 24..31; one-cycle read latency.
  always @(posedge clk) wall_rd_data <= (wall_addr >= 5'd24);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pack(input int px, input int py, input int c);
    return px * 256 + py * 16 + c;
  endfunction

  task automatic build_full(input int dx, input int dy);
    exp_q.delete();
    for (int py = 0; py < V; py++)
      for (int px = 0; px < H; px++) begin
        int c;
        if (px >= dx && px < dx + SW && py >= dy && py < dy + SH) c = int'(DUDE);
        else if (py == 3) c = int'(WALL);
        else c = int'(BG);
        exp_q.push_back(pack(px, py, c));
      end
  endtask

  task automatic add_box(input int ox, input int oy, input bit draw);
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++) begin
        int px, py, c;
        px = ox + i;
        py = oy + j;
        c  = draw ? int'(DUDE) : ((py == 3) ? int'(WALL) : int'(BG));
        if (px < H && py < V) exp_q.push_back(pack(px, py, c));
      end
  endtask

  task automatic run_op(input string tag, input bit inc, input int nx, input int ny,
                        input int exp_done, input bit poke);
    int done_cyc, first, n;
    done_cyc = -1;
    first    = -1;
    got_q.delete();
    @(negedge clk);
    mode_inc = inc;
    dude_x   = XW'(nx);
    dude_y   = YW'(ny);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode_inc = ~inc;
    dude_x   = '0;
    dude_y   = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (plot) begin
        got_q.push_back(pack(int'(x), int'(y), int'(colour)));
        fb[x][y] = colour;
        if (first < 0) first = cyc;
      end
      if (cyc == 1) check({tag, " busy_c1"}, 32'(busy), 32'd1);
      if (done) begin
        done_cyc = cyc;
        check({tag, " busy_at_done"}, 32'(busy), 32'd1);
        break;
      end
      // A start during the operation must be ignored.
      if (poke && cyc == 5) begin
        start    = 1'b1;
        mode_inc = 1'b1;
        dude_x   = 3'd5;
        dude_y   = 2'd0;
      end
      if (poke && cyc == 6) start = 1'b0;
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, " first_plot"}, 32'(first), 32'd2);
    check({tag, " plot_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s plot%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle_plot"}, 32'(plot), 32'd0);
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check("rst x", 32'(x), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst colour", 32'(colour), 32'd0);
    check("rst addr", 32'(wall_addr), 32'd0);
    check("rst plot", 32'(plot), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    build_full(1, 1);
    run_op("full11", 1'b0, 1, 1, 34, 1'b0);
    check("fb dude22", 32'(fb[2][2]), 32'(DUDE));
    check("fb wall03", 32'(fb[0][3]), 32'(WALL));
    check("fb bg00", 32'(fb[0][0]), 32'(BG));

    // Fresh reset: the first incremental request is forced to a full redraw.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    build_full(0, 0);
    run_op("forced_full", 1'b1, 0, 0, 34, 1'b1);

    exp_q.delete();
    add_box(0, 0, 1'b0);
    add_box(2, 2, 1'b1);
    run_op("inc22", 1'b1, 2, 2, 10, 1'b0);

    exp_q.delete();
    add_box(2, 2, 1'b0);
    add_box(3, 2, 1'b1);
    run_op("overlap", 1'b1, 3, 2, 10, 1'b0);
    check("ovl fb32", 32'(fb[3][2]), 32'(DUDE));
    check("ovl fb33", 32'(fb[3][3]), 32'(DUDE));
    check("ovl fb23", 32'(fb[2][3]), 32'(WALL));
    check("ovl fb22", 32'(fb[2][2]), 32'(BG));

    exp_q.delete();
    add_box(3, 2, 1'b0);
    add_box(7, 3, 1'b1);
    run_op("clip", 1'b1, 7, 3, 10, 1'b0);
    check("clip fb73", 32'(fb[7][3]), 32'(DUDE));

    // Reset in the middle of a full redraw.
    @(negedge clk);
    dude_x = 3'd1;
    dude_y = 2'd0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid busy_before", 32'(busy), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid x", 32'(x), 32'd0);
    check("mid y", 32'(y), 32'd0);
    check("mid colour", 32'(colour), 32'd0);
    check("mid plot", 32'(plot), 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    check("mid addr", 32'(wall_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    build_full(4, 1);
    run_op("after_rst", 1'b1, 4, 1, 34, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tower_frame_drawer.md
Name: tower_frame_drawer

Overview:
- Parametrised pixel-plot sequencer between the game FSM (setup/physics/display) and the VGA frame buffer.
- Generates x, y, colour and plot for the playfield from an external 1-bit wall map plus the player ("dude") sprite.
- Two modes: full-frame redraw, and incremental redraw (erase old sprite box, draw new one), so physics ticks need not repaint the whole screen.
- Start/busy/done handshake toward the game FSM.

Parameters:
- H_RES, 160, playfield width in pixels
- V_RES, 120, playfield height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ADDR_W, 15, wall map address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- COLOUR_W, 3, colour width
- SPR_W, 4, sprite width in pixels
- SPR_H, 4, sprite height in pixels
- BG_COLOUR, 3'b000, background colour
- WALL_COLOUR, 3'b111, wall colour
- DUDE_COLOUR, 3'b100, sprite colour

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mode_inc  in  1  1 = incremental redraw, 0 = full redraw; latched with start
- dude_x  in  X_W  sprite top-left x; latched with start
- dude_y  in  Y_W  sprite top-left y; latched with start
- wall_addr  out  ADDR_W  wall map read address, y*H_RES+x
- wall_rd_data  in  1  wall bit; valid exactly 1 cycle after wall_addr
- x  out  X_W  plot x
- y  out  Y_W  plot y
- colour  out  COLOUR_W  plot colour
- plot  out  1  write strobe to frame buffer
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse after the last plot slot

Behaviour:
- Reset, asynchronous:
  - x, y, colour, wall_addr = 0; plot, busy, done = 0
  - state = IDLE
  - prev_valid = 0; old position = 0
- States: IDLE, FULL, ERASE, DRAW, FLUSH, DONE.
- IDLE, start=1:
  - latch mode_inc, dude_x, dude_y
  - if mode_inc=1 and prev_valid=1, go to ERASE; otherwise go to FULL (first incremental request after reset is forced to full)
- Start arriving while not in IDLE is ignored, not queued.
- Two-stage pipeline:
  - stage 1 drives wall_addr for scan point (sx, sy)
  - stage 2 registers x=sx, y=sy, colour, plot one cycle later
  - every scan point costs exactly one cycle; no stalls
- FULL:
  - row-major scan, x 0..H_RES-1 inner, y 0..V_RES-1 outer; H_RES*V_RES points
  - colour priority: DUDE_COLOUR if the point lies in the latched sprite box, else WALL_COLOUR if wall_rd_data=1, else BG_COLOUR
- ERASE:
  - scan the SPR_W*SPR_H box at the old position
  - colour = WALL_COLOUR if wall_rd_data=1, else BG_COLOUR
- DRAW:
  - scan the box at the new position; colour = DUDE_COLOUR (map bit ignored)
  - ERASE always precedes DRAW, so the sprite wins where the boxes overlap
- Clipping:
  - box points with x >= H_RES or y >= V_RES are still counted (fixed cycle count) but give plot=0 and wall_addr=0
  - sprite coordinate arithmetic is done at X_W+1 / Y_W+1 bits so that wrap-around cannot alias into the visible area
- FLUSH: one cycle draining the last stage-2 plot. DONE: done=1 for one cycle, then IDLE.
- On DONE: old position <= latched position; prev_valid <= 1.
- Latency from the start-accept cycle (cycle 0):
  - first plot at cycle 2
  - full frame: last plot at cycle H_RES*V_RES+1, done at cycle H_RES*V_RES+2
  - incremental: 2*SPR_W*SPR_H plot slots, done at 2*SPR_W*SPR_H+2
- Outside plot slots, plot=0; x, y and colour hold their last values.
- resetn deasserted mid-operation: immediate return to reset values; the next start performs a full redraw.

Decomposition:
- Package tower_pkg holds:
  - state enum
  - default resolution and sprite constants
  - colour constants BG/WALL/DUDE
  - function for map address (y*H_RES+x)
- Sub-module tower_box_scanner: rectangle counter.
  - inputs: origin, extent, load, step
  - outputs: sx, sy, in_range, last
  - instanced once and reloaded for FULL/ERASE/DRAW

Test Plan (H_RES=8, V_RES=4, SPR_W=SPR_H=2, wall map: bit set iff y=3):
- Full redraw, start with dude=(1,1), mode_inc=0:
  - exactly 32 plots, row-major
  - (1,1),(2,1),(1,2),(2,2) = DUDE_COLOUR; row 3 = WALL_COLOUR; all others BG_COLOUR
  - done at cycle 34
- First post-reset start with mode_inc=1, dude=(0,0) -> behaves as full redraw: 32 plots, done at cycle 34.
- After the previous test, incremental start with dude=(2,2):
  - erase (0,0)..(1,1) with BG_COLOUR
  - draw (2,2),(3,2),(2,3),(3,3) with DUDE_COLOUR
  - 8 plot slots, done at cycle 10
- Incremental with old=(2,2), new=(3,2) (overlap):
  - final writes to (3,2) and (3,3) = DUDE_COLOUR
  - (2,3) erased to WALL_COLOUR
- Clipping, dude=(7,3), incremental:
  - only (7,3) plotted in DRAW
  - cycle count unchanged (done at cycle 10)
  - no plot with x>=8 or y>=4
- start pulsed during busy -> ignored; resetn low mid-FULL -> outputs zero immediately, next incremental start performs a full redraw.
